// File: rtl/addr_dly_tap_ctrl_if.sv
// Signal bundle between the training sequencer / IOD lane and the address
// delay-tap controller. The master side is the environment, the slave side is the controller.
interface addr_dly_tap_ctrl_if #(
    parameter int TAP_W = 8
);
    logic             train_start;
    logic             step_req;
    logic             step_dir;
    logic             busy;
    logic             done;
    logic             train_err;
    logic             step_err;
    logic [TAP_W-1:0] tap_cnt;
    logic [TAP_W-1:0] win_lo;
    logic [TAP_W-1:0] win_hi;
    logic             EYE_MONITOR_EARLY_0;
    logic             EYE_MONITOR_LATE_0;
    logic             DELAY_LINE_OUT_OF_RANGE_0;
    logic             DELAY_LINE_MOVE_0;
    logic             DELAY_LINE_DIRECTION_0;
    logic             DELAY_LINE_LOAD_0;
    logic             EYE_MONITOR_CLEAR_FLAGS_0;

    modport master (
        output train_start, step_req, step_dir,
        output EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0, DELAY_LINE_OUT_OF_RANGE_0,
        input  busy, done, train_err, step_err, tap_cnt, win_lo, win_hi,
        input  DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0,
        input  EYE_MONITOR_CLEAR_FLAGS_0
    );

    modport slave (
        input  train_start, step_req, step_dir,
        input  EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0, DELAY_LINE_OUT_OF_RANGE_0,
        output busy, done, train_err, step_err, tap_cnt, win_lo, win_hi,
        output DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0,
        output EYE_MONITOR_CLEAR_FLAGS_0
    );
endinterface

// File: rtl/addr_dly_tap_ctrl.sv
// Per-lane DDR4 address/command delay-line controller: manual single-tap steps
// and an auto-centre sweep that parks the delay at the middle of the first clean eye window.
module addr_dly_tap_ctrl #(
    parameter int TAP_W      = 8,
    parameter int INIT_TAP   = 1,
    parameter int MAX_TAP    = 127,
    parameter int SETTLE_CYC = 8,
    parameter int SAMPLE_CYC = 16,
    parameter int MOVE_GAP   = 4
) (
    input  logic               FAB_CLK,
    input  logic               ARST_N,
    addr_dly_tap_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_GAP    = 4'd2,
        S_CLR    = 4'd3,
        S_SETTLE = 4'd4,
        S_SAMPLE = 4'd5,
        S_STEP   = 4'd6,
        S_CENTER = 4'd7,
        S_FINISH = 4'd8
    } state_t;

    localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);
    localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
    localparam logic [15:0]      GAP_END  = 16'(MOVE_GAP - 1);
    localparam logic [15:0]      SET_END  = 16'(SETTLE_CYC - 1);
    localparam logic [15:0]      SMP_END  = 16'(SAMPLE_CYC - 1);

    state_t           state_r;
    state_t           ret_r;
    logic [15:0]      cnt_r;
    logic             bad_r;
    logic             found_r;
    logic             moved_r;
    logic             dir_r;

    logic [TAP_W:0]   sum_s;
    logic [TAP_W-1:0] target_s;
    logic             bad_now_s;
    logic             tap_max_s;
    logic             tap_min_s;

    // Centre target (one extra bit so the sum cannot wrap) and per-cycle eye/boundary flags.
    always_comb begin
        sum_s     = {1'b0, bus.win_lo} + {1'b0, bus.win_hi};
        target_s  = TAP_W'(sum_s >> 1);
        bad_now_s = bad_r | bus.EYE_MONITOR_EARLY_0 | bus.EYE_MONITOR_LATE_0;
        tap_max_s = (bus.tap_cnt == TAP_MAX);
        tap_min_s = (bus.tap_cnt == {TAP_W{1'b0}});
    end

    // Controller FSM; every IOD-facing pulse is raised on entry into the state that owns it.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_r                       <= S_IDLE;
            ret_r                         <= S_IDLE;
            cnt_r                         <= 16'd0;
            bad_r                         <= 1'b0;
            found_r                       <= 1'b0;
            moved_r                       <= 1'b0;
            dir_r                         <= 1'b0;
            bus.busy                      <= 1'b0;
            bus.done                      <= 1'b0;
            bus.train_err                 <= 1'b0;
            bus.step_err                  <= 1'b0;
            bus.tap_cnt                   <= TAP_INIT;
            bus.win_lo                    <= {TAP_W{1'b0}};
            bus.win_hi                    <= {TAP_W{1'b0}};
            bus.DELAY_LINE_MOVE_0         <= 1'b0;
            bus.DELAY_LINE_DIRECTION_0    <= 1'b0;
            bus.DELAY_LINE_LOAD_0         <= 1'b0;
            bus.EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
        end else begin
            bus.DELAY_LINE_MOVE_0         <= 1'b0;
            bus.DELAY_LINE_LOAD_0         <= 1'b0;
            bus.EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
            bus.done                      <= 1'b0;
            bus.step_err                  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.train_start) begin
                        state_r               <= S_LOAD;
                        ret_r                 <= S_CLR;
                        bus.busy              <= 1'b1;
                        bus.train_err         <= 1'b0;
                        bus.win_lo            <= {TAP_W{1'b0}};
                        bus.win_hi            <= {TAP_W{1'b0}};
                        found_r               <= 1'b0;
                        bus.DELAY_LINE_LOAD_0 <= 1'b1;
                        bus.tap_cnt           <= TAP_INIT;
                    end else if (bus.step_req) begin
                        state_r  <= S_STEP;
                        bus.busy <= 1'b1;
                        dir_r    <= bus.step_dir;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    cnt_r   <= 16'd0;
                    moved_r <= 1'b0;
                    state_r <= S_GAP;
                end
                S_GAP: begin
                    if (cnt_r == GAP_END) begin
                        cnt_r   <= 16'd0;
                        moved_r <= 1'b0;
                        if (moved_r && bus.DELAY_LINE_OUT_OF_RANGE_0) begin
                            // The line refused the move, so the tracked tap steps back.
                            bus.tap_cnt <= bus.DELAY_LINE_DIRECTION_0 ? (bus.tap_cnt - TAP_ONE)
                                                                      : (bus.tap_cnt + TAP_ONE);
                            case (ret_r)
                                S_CLR: begin
                                    state_r <= S_CENTER;
                                end
                                S_FINISH: begin
                                    state_r      <= S_FINISH;
                                    bus.step_err <= 1'b1;
                                    bus.done     <= 1'b1;
                                end
                                default: begin
                                    state_r  <= S_FINISH;
                                    bus.done <= 1'b1;
                                end
                            endcase
                        end else begin
                            state_r                       <= ret_r;
                            bus.EYE_MONITOR_CLEAR_FLAGS_0 <= (ret_r == S_CLR);
                            bus.done                      <= (ret_r == S_FINISH);
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                S_CLR: begin
                    cnt_r   <= 16'd0;
                    state_r <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_r == SET_END) begin
                        cnt_r   <= 16'd0;
                        bad_r   <= 1'b0;
                        state_r <= S_SAMPLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                S_SAMPLE: begin
                    if (cnt_r == SMP_END) begin
                        cnt_r <= 16'd0;
                        bad_r <= 1'b0;
                        if (!bad_now_s) begin
                            if (!found_r) begin
                                found_r    <= 1'b1;
                                bus.win_lo <= bus.tap_cnt;
                            end else begin
                                found_r <= 1'b1;
                            end
                            bus.win_hi <= bus.tap_cnt;
                        end else begin
                            found_r <= found_r;
                        end
                        if ((bad_now_s && found_r) || tap_max_s) begin
                            state_r <= S_CENTER;
                        end else begin
                            bus.DELAY_LINE_MOVE_0      <= 1'b1;
                            bus.DELAY_LINE_DIRECTION_0 <= 1'b1;
                            bus.tap_cnt                <= bus.tap_cnt + TAP_ONE;
                            ret_r                      <= S_CLR;
                            moved_r                    <= 1'b1;
                            state_r                    <= S_GAP;
                        end
                    end else begin
                        bad_r <= bad_now_s;
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                S_CENTER: begin
                    if (!found_r) begin
                        bus.train_err         <= 1'b1;
                        bus.DELAY_LINE_LOAD_0 <= 1'b1;
                        bus.tap_cnt           <= TAP_INIT;
                        ret_r                 <= S_FINISH;
                        state_r               <= S_LOAD;
                    end else if (bus.tap_cnt == target_s) begin
                        bus.done <= 1'b1;
                        state_r  <= S_FINISH;
                    end else begin
                        bus.DELAY_LINE_MOVE_0      <= 1'b1;
                        bus.DELAY_LINE_DIRECTION_0 <= 1'b0;
                        bus.tap_cnt                <= bus.tap_cnt - TAP_ONE;
                        ret_r                      <= S_CENTER;
                        moved_r                    <= 1'b1;
                        cnt_r                      <= 16'd0;
                        state_r                    <= S_GAP;
                    end
                end
                S_STEP: begin
                    if ((dir_r && tap_max_s) || (!dir_r && tap_min_s)) begin
                        bus.step_err <= 1'b1;
                        bus.done     <= 1'b1;
                        state_r      <= S_FINISH;
                    end else begin
                        bus.DELAY_LINE_MOVE_0      <= 1'b1;
                        bus.DELAY_LINE_DIRECTION_0 <= dir_r;
                        bus.tap_cnt                <= dir_r ? (bus.tap_cnt + TAP_ONE)
                                                            : (bus.tap_cnt - TAP_ONE);
                        ret_r                      <= S_FINISH;
                        moved_r                    <= 1'b1;
                        cnt_r                      <= 16'd0;
                        state_r                    <= S_GAP;
                    end
                end
                S_FINISH: begin
                    bus.busy <= 1'b0;
                    state_r  <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_addr_dly_tap_ctrl.sv
// Bench for addr_dly_tap_ctrl: an IOD lane model with a configurable clean eye window
// and out-of-range limit, plus a sweep/centre reference model computed from the training rules.
module tb_addr_dly_tap_ctrl;
    localparam int TAP_W    = 8;
    localparam int INIT_TAP = 1;
    localparam int MAX_TAP  = 127;

    logic FAB_CLK = 1'b0;
    logic ARST_N  = 1'b0;

    addr_dly_tap_ctrl_if #(.TAP_W(TAP_W)) bus ();

    addr_dly_tap_ctrl #(
        .TAP_W(TAP_W), .INIT_TAP(INIT_TAP), .MAX_TAP(MAX_TAP),
        .SETTLE_CYC(8), .SAMPLE_CYC(16), .MOVE_GAP(4)
    ) dut (
        .FAB_CLK(FAB_CLK),
        .ARST_N (ARST_N),
        .bus    (bus)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int total = 0;
    int bad   = 0;

    int clean_lo = 1000;
    int clean_hi = -1;
    int oor_tap  = 1000;
    int m_tap    = INIT_TAP;

    int       hw_tap = INIT_TAP;
    logic     oor_lvl = 1'b0;
    logic [1:0] rnd = 2'b00;
    int n_inc = 0, n_dec = 0, n_load = 0, n_clr = 0, n_done = 0, n_serr = 0;

    // Lane model: tracks the physical tap, refuses moves past the limit, counts pulses.
    always @(negedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            hw_tap  <= INIT_TAP;
            oor_lvl <= 1'b0;
        end else begin
            rnd <= 2'($urandom);
            if (bus.DELAY_LINE_LOAD_0) begin
                n_load  <= n_load + 1;
                hw_tap  <= INIT_TAP;
                oor_lvl <= 1'b0;
            end else if (bus.DELAY_LINE_MOVE_0) begin
                if (bus.DELAY_LINE_DIRECTION_0) begin
                    n_inc <= n_inc + 1;
                    if (hw_tap + 1 >= oor_tap) oor_lvl <= 1'b1;
                    else begin
                        hw_tap  <= hw_tap + 1;
                        oor_lvl <= 1'b0;
                    end
                end else begin
                    n_dec   <= n_dec + 1;
                    hw_tap  <= hw_tap - 1;
                    oor_lvl <= 1'b0;
                end
            end
            if (bus.EYE_MONITOR_CLEAR_FLAGS_0) n_clr <= n_clr + 1;
            if (bus.done) n_done <= n_done + 1;
            if (bus.step_err) n_serr <= n_serr + 1;
        end
    end

    wire eye_clean = (hw_tap >= clean_lo) && (hw_tap <= clean_hi);
    assign bus.EYE_MONITOR_EARLY_0       = !eye_clean && rnd[0];
    assign bus.EYE_MONITOR_LATE_0        = !eye_clean && (!rnd[0] || rnd[1]);
    assign bus.DELAY_LINE_OUT_OF_RANGE_0 = oor_lvl;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: sweep up from INIT, first contiguous clean run, floor midpoint, move down to it.
    function automatic void model_train(input int lo, input int hi, input int oor,
                                        output int e_lo, output int e_hi, output int e_tap,
                                        output int e_inc, output int e_dec, output int e_err,
                                        output int e_load);
        int t;
        bit found;
        t = INIT_TAP; found = 1'b0; e_lo = 0; e_hi = 0; e_inc = 0;
        for (int g = 0; g < 1000; g++) begin
            if (t >= lo && t <= hi) begin
                if (!found) begin found = 1'b1; e_lo = t; end
                e_hi = t;
            end else if (found) break;
            if (t == MAX_TAP) break;
            e_inc++;
            if (t + 1 >= oor) break;
            t++;
        end
        if (!found) begin
            e_err = 1; e_load = 2; e_tap = INIT_TAP; e_dec = 0;
        end else begin
            e_err = 0; e_load = 1; e_tap = (e_lo + e_hi) / 2; e_dec = t - e_tap;
        end
    endfunction

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.busy === 1'b1 && k < 8000) begin
            @(negedge FAB_CLK);
            k++;
        end
        chk({tag, "_timeout"}, int'(k < 8000), 1);
        #1;
    endtask

    task automatic run_train(input string tag, input int lo, input int hi, input int oor,
                             input bit with_step, input bit inject);
        int e_lo, e_hi, e_tap, e_inc, e_dec, e_err, e_load;
        int s_inc, s_dec, s_load, s_done, s_serr;
        clean_lo = lo; clean_hi = hi; oor_tap = oor;
        model_train(lo, hi, oor, e_lo, e_hi, e_tap, e_inc, e_dec, e_err, e_load);
        s_inc = n_inc; s_dec = n_dec; s_load = n_load; s_done = n_done; s_serr = n_serr;
        @(negedge FAB_CLK);
        bus.train_start = 1'b1; bus.step_req = with_step; bus.step_dir = 1'b1;
        @(negedge FAB_CLK);
        bus.train_start = 1'b0; bus.step_req = 1'b0;
        if (inject) begin
            repeat (40) @(negedge FAB_CLK);
            bus.train_start = 1'b1; bus.step_req = 1'b1;
            @(negedge FAB_CLK);
            bus.train_start = 1'b0; bus.step_req = 1'b0;
        end
        wait_idle(tag);
        chk({tag, "_tap"},    int'(bus.tap_cnt),   e_tap);
        chk({tag, "_win_lo"}, int'(bus.win_lo),    e_lo);
        chk({tag, "_win_hi"}, int'(bus.win_hi),    e_hi);
        chk({tag, "_err"},    int'(bus.train_err), e_err);
        chk({tag, "_inc"},    n_inc - s_inc,       e_inc);
        chk({tag, "_dec"},    n_dec - s_dec,       e_dec);
        chk({tag, "_load"},   n_load - s_load,     e_load);
        chk({tag, "_done"},   n_done - s_done,     1);
        chk({tag, "_serr"},   n_serr - s_serr,     0);
        m_tap = e_tap;
    endtask

    task automatic run_step(input string tag, input bit dir);
        int e_err, e_tap, s_inc, s_dec, s_done, s_serr;
        e_err = dir ? int'(m_tap == MAX_TAP) : int'(m_tap == 0);
        e_tap = (e_err == 1) ? m_tap : (dir ? m_tap + 1 : m_tap - 1);
        oor_tap = 1000;
        s_inc = n_inc; s_dec = n_dec; s_done = n_done; s_serr = n_serr;
        @(negedge FAB_CLK);
        bus.step_req = 1'b1; bus.step_dir = dir;
        @(negedge FAB_CLK);
        bus.step_req = 1'b0;
        wait_idle(tag);
        chk({tag, "_tap"},  int'(bus.tap_cnt), e_tap);
        chk({tag, "_serr"}, n_serr - s_serr,   e_err);
        chk({tag, "_inc"},  n_inc - s_inc,     (e_err == 0 && dir) ? 1 : 0);
        chk({tag, "_dec"},  n_dec - s_dec,     (e_err == 0 && !dir) ? 1 : 0);
        chk({tag, "_done"}, n_done - s_done,   1);
        if (e_err == 0) chk({tag, "_dir"}, int'(bus.DELAY_LINE_DIRECTION_0), int'(dir));
        m_tap = e_tap;
    endtask

    initial begin
        int lo, hi, oor, k, s_any;
        bus.train_start = 1'b0;
        bus.step_req    = 1'b0;
        bus.step_dir    = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        ARST_N = 1'b1;
        s_any = n_inc + n_dec + n_load + n_clr + n_done + n_serr;
        repeat (10) @(negedge FAB_CLK);
        chk("rst_busy",  int'(bus.busy),      0);
        chk("rst_done",  int'(bus.done),      0);
        chk("rst_terr",  int'(bus.train_err), 0);
        chk("rst_tap",   int'(bus.tap_cnt),   INIT_TAP);
        chk("rst_winlo", int'(bus.win_lo),    0);
        chk("rst_winhi", int'(bus.win_hi),    0);
        chk("rst_dir",   int'(bus.DELAY_LINE_DIRECTION_0), 0);
        chk("rst_pulses", n_inc + n_dec + n_load + n_clr + n_done + n_serr - s_any, 0);

        run_train("win20_40", 20, 40, 1000, 1'b0, 1'b0);
        run_train("all_dirty", 1000, -1, 1000, 1'b0, 1'b0);
        run_train("win127", 127, 127, 1000, 1'b0, 1'b0);
        run_step("step_max_up", 1'b1);
        run_step("step_max_dn", 1'b0);
        run_train("oor60", 50, 59, 60, 1'b0, 1'b0);
        run_train("train_and_step", 30, 35, 1000, 1'b1, 1'b0);
        run_train("busy_ignore", 10, 15, 1000, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            lo  = int'($urandom_range(2, 100));
            hi  = lo + int'($urandom_range(0, 20));
            oor = ($urandom_range(0, 1) == 1) ? lo + int'($urandom_range(0, 25)) : 1000;
            run_train($sformatf("rnd_train%0d", i), lo, hi, oor, 1'b0, 1'b0);
            for (int j = 0; j < 3; j++) run_step($sformatf("rnd_step%0d_%0d", i, j), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while the sweep is sampling tap 25.
        clean_lo = 20; clean_hi = 40; oor_tap = 1000;
        @(negedge FAB_CLK);
        bus.train_start = 1'b1;
        @(negedge FAB_CLK);
        bus.train_start = 1'b0;
        k = 0;
        while (int'(bus.tap_cnt) != 25 && k < 5000) begin
            @(negedge FAB_CLK);
            k++;
        end
        chk("arst_reach25", int'(k < 5000), 1);
        repeat (16) @(negedge FAB_CLK);
        chk("arst_pre_winlo", int'(bus.win_lo), 20);
        #2 ARST_N = 1'b0;
        #1;
        chk("arst_busy",  int'(bus.busy),              0);
        chk("arst_tap",   int'(bus.tap_cnt),           INIT_TAP);
        chk("arst_winlo", int'(bus.win_lo),            0);
        chk("arst_winhi", int'(bus.win_hi),            0);
        chk("arst_clr",   int'(bus.EYE_MONITOR_CLEAR_FLAGS_0), 0);
        chk("arst_move",  int'(bus.DELAY_LINE_MOVE_0), 0);
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        repeat (5) @(negedge FAB_CLK);
        chk("arst_idle_busy", int'(bus.busy), 0);
        m_tap = INIT_TAP;
        run_train("retrain", 20, 40, 1000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
